// File: rtl/rsfq_gate_sequencer.sv
// Sequencer for one clocked RSFQ AND2-class gate cell shared by two requesters.
// Drives toggle-encoded a/b/clk lines, enforces setup/hold spacing in system
// clock cycles, and decodes the q toggle into a checked, handshaked result.
module rsfq_gate_sequencer #(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned RESP_CYC  = 8,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_valid,
  input  logic req0_a,
  input  logic req0_b,
  output logic req0_ready,
  input  logic req1_valid,
  input  logic req1_a,
  input  logic req1_b,
  output logic req1_ready,
  output logic gate_a,
  output logic gate_b,
  output logic gate_clk,
  input  logic gate_q,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic rsp_id,
  output logic rsp_q,
  output logic rsp_err,
  output logic spurious_err,
  output logic busy
);

  // The response window must also cover the hold time, so the next a/b toggle
  // (which can only follow the window) never violates hold.
  localparam int unsigned WaitCyc = (RESP_CYC > HOLD_CYC) ? RESP_CYC : HOLD_CYC;
  localparam int unsigned CntMax  = (SETUP_CYC > WaitCyc) ? SETUP_CYC : WaitCyc;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;

  // The DATA->SETUP->CLK path spans SETUP_CYC cycles from the a/b toggle to the
  // clk toggle, so SETUP itself holds for SETUP_CYC-1 cycles (none when 1).
  localparam logic [CntW-1:0] SetupLast = CntW'((SETUP_CYC > 1) ? SETUP_CYC - 2 : 0);
  localparam logic [CntW-1:0] WaitLast  = CntW'(WaitCyc - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StData  = 3'd1,
    StSetup = 3'd2,
    StClk   = 3'd3,
    StWait  = 3'd4,
    StResp  = 3'd5
  } state_e;

  state_e          r_state, w_state_nxt;
  logic            r_last_grant, w_last_grant_nxt;
  logic            r_op_a, w_op_a_nxt;
  logic            r_op_b, w_op_b_nxt;
  logic            r_op_id, w_op_id_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_gate_a, w_gate_a_nxt;
  logic            r_gate_b, w_gate_b_nxt;
  logic            r_gate_clk, w_gate_clk_nxt;
  logic            r_q_prev;
  logic            r_q_prev_vld;
  logic            r_q_seen, w_q_seen_nxt;
  logic            r_q_dbl, w_q_dbl_nxt;
  logic            r_rsp_q, w_rsp_q_nxt;
  logic            r_rsp_err, w_rsp_err_nxt;
  logic            r_rsp_id, w_rsp_id_nxt;
  logic            r_spur, w_spur_nxt;

  logic            w_grant0;
  logic            w_grant1;
  logic            w_q_tgl;
  logic            w_seen_now;
  logic            w_dbl_now;

  // q edge detect; suppressed until q_prev has been loaded once after reset.
  assign w_q_tgl    = r_q_prev_vld & (gate_q ^ r_q_prev);
  assign w_seen_now = r_q_seen | w_q_tgl;
  assign w_dbl_now  = r_q_dbl | (r_q_seen & w_q_tgl);

  // Round-robin grant in IDLE; on contention the requester not granted last wins.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == StIdle) begin
      if (req0_valid && req1_valid) begin
        if (r_last_grant) begin
          w_grant0 = 1'b1;
        end else begin
          w_grant1 = 1'b1;
        end
      end else if (req0_valid) begin
        w_grant0 = 1'b1;
      end else if (req1_valid) begin
        w_grant1 = 1'b1;
      end
    end
  end

  // Sticky spurious-toggle flag: any q toggle outside the WAIT window.
  always_comb begin
    w_spur_nxt = r_spur | (w_q_tgl & (r_state != StWait));
  end

  // FSM next state, operand latch, toggle-line and response updates.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_op_a_nxt       = r_op_a;
    w_op_b_nxt       = r_op_b;
    w_op_id_nxt      = r_op_id;
    w_cnt_nxt        = r_cnt;
    w_gate_a_nxt     = r_gate_a;
    w_gate_b_nxt     = r_gate_b;
    w_gate_clk_nxt   = r_gate_clk;
    w_q_seen_nxt     = r_q_seen;
    w_q_dbl_nxt      = r_q_dbl;
    w_rsp_q_nxt      = r_rsp_q;
    w_rsp_err_nxt    = r_rsp_err;
    w_rsp_id_nxt     = r_rsp_id;

    case (r_state)
      StIdle: begin
        if (w_grant0 || w_grant1) begin
          w_op_a_nxt       = w_grant1 ? req1_a : req0_a;
          w_op_b_nxt       = w_grant1 ? req1_b : req0_b;
          w_op_id_nxt      = w_grant1;
          w_last_grant_nxt = w_grant1;
          w_state_nxt      = StData;
        end
      end

      StData: begin
        // A '1' operand is one pulse, i.e. one level change on its line.
        w_gate_a_nxt = r_gate_a ^ r_op_a;
        w_gate_b_nxt = r_gate_b ^ r_op_b;
        w_cnt_nxt    = '0;
        w_state_nxt  = (SETUP_CYC > 1) ? StSetup : StClk;
      end

      StSetup: begin
        if (r_cnt == SetupLast) begin
          w_state_nxt = StClk;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end

      StClk: begin
        w_gate_clk_nxt = ~r_gate_clk;
        w_q_seen_nxt   = 1'b0;
        w_q_dbl_nxt    = 1'b0;
        w_cnt_nxt      = '0;
        w_state_nxt    = StWait;
      end

      StWait: begin
        w_q_seen_nxt = w_seen_now;
        w_q_dbl_nxt  = w_dbl_now;
        if (r_cnt == WaitLast) begin
          // Include a toggle arriving in the final window cycle.
          w_rsp_q_nxt   = w_seen_now;
          w_rsp_err_nxt = (w_seen_now != (r_op_a & r_op_b)) | w_dbl_now;
          w_rsp_id_nxt  = r_op_id;
          w_state_nxt   = StResp;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end

      StResp: begin
        if (rsp_ready) begin
          w_state_nxt = StIdle;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_op_a       <= 1'b0;
      r_op_b       <= 1'b0;
      r_op_id      <= 1'b0;
      r_cnt        <= '0;
      r_gate_a     <= 1'b0;
      r_gate_b     <= 1'b0;
      r_gate_clk   <= 1'b0;
      r_q_seen     <= 1'b0;
      r_q_dbl      <= 1'b0;
      r_rsp_q      <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_spur       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_op_a       <= w_op_a_nxt;
      r_op_b       <= w_op_b_nxt;
      r_op_id      <= w_op_id_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gate_a     <= w_gate_a_nxt;
      r_gate_b     <= w_gate_b_nxt;
      r_gate_clk   <= w_gate_clk_nxt;
      r_q_seen     <= w_q_seen_nxt;
      r_q_dbl      <= w_q_dbl_nxt;
      r_rsp_q      <= w_rsp_q_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
      r_rsp_id     <= w_rsp_id_nxt;
      r_spur       <= w_spur_nxt;
    end
  end

  // q history for edge detection; first clock after reset only loads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_prev     <= 1'b0;
      r_q_prev_vld <= 1'b0;
    end else begin
      r_q_prev     <= gate_q;
      r_q_prev_vld <= 1'b1;
    end
  end

  assign req0_ready   = w_grant0;
  assign req1_ready   = w_grant1;
  assign gate_a       = r_gate_a;
  assign gate_b       = r_gate_b;
  assign gate_clk     = r_gate_clk;
  assign rsp_valid    = (r_state == StResp);
  assign rsp_id       = r_rsp_id;
  assign rsp_q        = r_rsp_q;
  assign rsp_err      = r_rsp_err;
  assign spurious_err = r_spur;
  assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_rsfq_gate_sequencer.sv
// Directed bench for rsfq_gate_sequencer with a behavioural AND2 toggle model
// and a response scoreboard filled when requests are issued.
module tb_rsfq_gate_sequencer;

  localparam int unsigned S = 4;
  localparam int unsigned R = 8;
  localparam int unsigned H = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid, req0_a, req0_b, req0_ready;
  logic req1_valid, req1_a, req1_b, req1_ready;
  logic gate_a, gate_b, gate_clk, gate_q;
  logic rsp_valid, rsp_ready, rsp_id, rsp_q, rsp_err, spurious_err, busy;

  rsfq_gate_sequencer #(
    .SETUP_CYC (S),
    .RESP_CYC  (R),
    .HOLD_CYC  (H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_ready   (req1_ready),
    .gate_a       (gate_a),
    .gate_b       (gate_b),
    .gate_clk     (gate_clk),
    .gate_q       (gate_q),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_q        (rsp_q),
    .rsp_err      (rsp_err),
    .spurious_err (spurious_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Gate model: stores a/b pulses, on a clk pulse fires q if both were seen.
  // f_q lets the bench inject extra q toggles independently of the model.
  logic m_a = 1'b0, m_b = 1'b0, m_q = 1'b0, f_q = 1'b0;
  logic ma_p = 1'b0, mb_p = 1'b0, mc_p = 1'b0;
  assign gate_q = m_q ^ f_q;

  always @(negedge clk) begin
    ma_p <= gate_a;
    mb_p <= gate_b;
    mc_p <= gate_clk;
    if (!rst_n) begin
      m_a <= 1'b0;
      m_b <= 1'b0;
    end else if (gate_clk !== mc_p) begin
      if (m_a && m_b) m_q <= ~m_q;
      m_a <= 1'b0;
      m_b <= 1'b0;
    end else begin
      if (gate_a !== ma_p) m_a <= 1'b1;
      if (gate_b !== mb_p) m_b <= 1'b1;
    end
  end

  // Line-timing monitor: setup gap and minimum clk->next a/b gap in cycles.
  int   cyc = 0, t_ab = 0, t_clk = 0, last_setup = 0, min_hold = 100000;
  logic pa = 1'b0, pb = 1'b0, pc = 1'b0;
  bit   clk_seen = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    pa  <= gate_a;
    pb  <= gate_b;
    pc  <= gate_clk;
    if (!rst_n) begin
      clk_seen <= 1'b0;
    end else begin
      if (gate_a !== pa || gate_b !== pb) begin
        t_ab <= cyc;
        if (clk_seen && (cyc - t_clk) < min_hold) min_hold <= cyc - t_clk;
      end
      if (gate_clk !== pc) begin
        t_clk      <= cyc;
        clk_seen   <= 1'b1;
        last_setup <= cyc - t_ab;
      end
    end
  end

  typedef struct packed {
    logic id;
    logic q;
    logic err;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic push(input logic id, input logic q, input logic err);
    exp_t e;
    e.id  = id;
    e.q   = q;
    e.err = err;
    sb.push_back(e);
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic send(input string tag, input bit who, input logic a, input logic b);
    bit ok = 1'b0;
    if (who) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 100; i++) begin
      #1;
      if (who ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_ready"}, 32'(ok), 1);
    check({tag, "_other_ready"}, 32'(who ? req0_ready : req1_ready), 0);
    @(negedge clk);
    check({tag, "_ready_pulse"}, 32'(req0_ready | req1_ready), 0);
    if (who) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_rsp_seen"}, 32'(ok), 1);
  endtask

  task automatic wait_clk_tgl(input string tag);
    bit   ok = 1'b0;
    logic c0 = gate_clk;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gate_clk !== c0) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_clk_tgl"}, 32'(ok), 1);
  endtask

  // Compare the held response to the scoreboard head, then handshake it.
  task automatic take_rsp(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_rsp_id"}, 32'(rsp_id), 32'(e.id));
      check({tag, "_rsp_q"}, 32'(rsp_q), 32'(e.q));
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'(e.err));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_dropped"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] snap;
  bit         stable_ok, noready_ok, any_ok;

  initial begin
    req0_valid = 1'b0; req0_a = 1'b0; req0_b = 1'b0;
    req1_valid = 1'b0; req1_a = 1'b0; req1_b = 1'b0;
    rsp_ready  = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({req0_ready, req1_ready, gate_a, gate_b, gate_clk, rsp_valid,
                             rsp_id, rsp_q, rsp_err, spurious_err, busy}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // req0 a=1 b=1, model fires q.
    push(1'b0, 1'b1, 1'b0);
    send("t1", 1'b0, 1'b1, 1'b1);
    check("t1_busy", 32'(busy), 1);
    wait_rsp("t1");
    check("t1_gate_a", 32'(gate_a), 1);
    check("t1_gate_b", 32'(gate_b), 1);
    check("t1_gate_clk", 32'(gate_clk), 1);
    check("t1_setup_gap", 32'(last_setup), S);
    take_rsp("t1");

    // req1 a=1 b=0, model silent; b line must not move.
    push(1'b1, 1'b0, 1'b0);
    send("t2", 1'b1, 1'b1, 1'b0);
    wait_rsp("t2");
    check("t2_gate_a", 32'(gate_a), 0);
    check("t2_gate_b", 32'(gate_b), 1);
    check("t2_gate_clk", 32'(gate_clk), 0);
    check("t2_setup_gap", 32'(last_setup), S);
    take_rsp("t2");

    // Two q toggles in one window -> error even though q matches a&b.
    push(1'b0, 1'b1, 1'b1);
    send("dbl", 1'b0, 1'b1, 1'b1);
    wait_clk_tgl("dbl");
    repeat (2) @(negedge clk);
    f_q = ~f_q;
    wait_rsp("dbl");
    take_rsp("dbl");

    // req1 a=1 b=0 with a forced q toggle in the window.
    push(1'b1, 1'b1, 1'b1);
    send("t2b", 1'b1, 1'b1, 1'b0);
    wait_clk_tgl("t2b");
    f_q = ~f_q;
    wait_rsp("t2b");
    take_rsp("t2b");
    check("spur_clean", 32'(spurious_err), 0);

    // Both requesters valid for 4 operations: grants alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(1'b0, 1'b1, 1'b0);
      else            push(1'b1, 1'b0, 1'b0);
    end
    req0_valid = 1'b1; req0_a = 1'b1; req0_b = 1'b1;
    req1_valid = 1'b1; req1_a = 1'b0; req1_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      any_ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        #1;
        if (req0_ready || req1_ready) begin
          any_ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("rr_ready", 32'(any_ok), 1);
      check("rr_grant", 32'({req1_ready, req0_ready}), (k % 2 == 1) ? 2 : 1);
      wait_rsp("rr");
      take_rsp("rr");
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("hold_ge3", 32'(min_hold >= 3 && min_hold >= int'(H)), 1);
    // WAIT window + one RESP cycle + IDLE + DATA.
    check("hold_gap", 32'(min_hold), R + 3);

    // Consumer stalls 10 cycles; another request waits meanwhile.
    push(1'b0, 1'b1, 1'b0);
    send("stall", 1'b0, 1'b1, 1'b1);
    wait_rsp("stall");
    snap = {rsp_id, rsp_q, rsp_err, gate_a, gate_b, gate_clk};
    req1_valid = 1'b1; req1_a = 1'b1; req1_b = 1'b1;
    stable_ok  = 1'b1;
    noready_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if ({rsp_id, rsp_q, rsp_err, gate_a, gate_b, gate_clk} !== snap || !rsp_valid)
        stable_ok = 1'b0;
      if (req0_ready || req1_ready) noready_ok = 1'b0;
    end
    check("stall_stable", 32'(stable_ok), 1);
    check("stall_no_ready", 32'(noready_ok), 1);
    check("stall_busy", 32'(busy), 1);
    take_rsp("stall");
    check("stall_idle_ready", 32'(req1_ready), 1);
    push(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp("stall_next");
    take_rsp("stall_next");

    // q toggle while IDLE -> sticky spurious error.
    check("spur_pre", 32'(spurious_err), 0);
    @(negedge clk);
    f_q = ~f_q;
    @(negedge clk);
    check("spur_set", 32'(spurious_err), 1);
    push(1'b0, 1'b1, 1'b0);
    send("t5", 1'b0, 1'b1, 1'b1);
    wait_rsp("t5");
    take_rsp("t5");
    check("spur_sticky", 32'(spurious_err), 1);

    // Reset during SETUP drops the operation.
    send("t6", 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_outs", 32'({req0_ready, req1_ready, gate_a, gate_b, gate_clk, rsp_valid,
                           rsp_id, rsp_q, rsp_err, spurious_err, busy}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_stale", 32'(rsp_valid), 0);
    check("rst_spur_clear", 32'(spurious_err), 0);
    check("rst_busy", 32'(busy), 0);
    push(1'b1, 1'b1, 1'b0);
    send("t6b", 1'b1, 1'b1, 1'b1);
    wait_rsp("t6b");
    take_rsp("t6b");
    check("sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
